// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_pkg
// Description : Width derivation helpers for the pipelined integer square root.
// Revision    : 1.0 - initial release
// ============================================================================
package isqrt_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    function automatic int isqrt_stages(int w);
        return w / 2;
    endfunction

    function automatic int isqrt_root_w(int w);
        return w / 2;
    endfunction

    // Partial remainder carries two spare bits so (rem << 2) | pair never wraps.
    function automatic int isqrt_prem_w(int w);
        return w / 2 + 2;
    endfunction

    function automatic int isqrt_rem_w(int w);
        return w / 2 + 1;
    endfunction

    function automatic bit isqrt_width_ok(int w);
        return ((w % 2) == 0) && (w >= 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_stage.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_stage
// Description : One restoring digit-recurrence step of the integer square root,
//               with load-on-valid data registers and a free-running valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_stage
    import isqrt_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter bit  KEEP_REM = 1'b1,
    localparam int c_ROOT_W = isqrt_root_w(WIDTH),
    localparam int c_PREM_W = isqrt_prem_w(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_vld,
    input  logic [WIDTH-1:0]    i_rad,
    input  logic [c_PREM_W-1:0] i_rem,
    input  logic [c_ROOT_W-1:0] i_root,
    output logic                o_vld,
    output logic [WIDTH-1:0]    o_rad,
    output logic [c_PREM_W-1:0] o_rem,
    output logic [c_ROOT_W-1:0] o_root
);

    logic [c_PREM_W-1:0] w_rem_sh;
    logic [c_PREM_W-1:0] w_trial;
    logic                w_ge;

    logic                r_vld;
    logic [WIDTH-1:0]    r_rad;
    logic [c_PREM_W-1:0] r_rem;
    logic [c_ROOT_W-1:0] r_root;

    assign w_rem_sh = (i_rem << 2) | c_PREM_W'(i_rad[WIDTH-1 -: 2]);
    assign w_trial  = (c_PREM_W'(i_root) << 2) | c_PREM_W'(1);
    assign w_ge     = (w_rem_sh >= w_trial);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld  <= 1'b0;
            r_rad  <= '0;
            r_root <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_rad  <= i_rad << 2;
                r_root <= (i_root << 1) | c_ROOT_W'(w_ge);
            end
        end
    end

    // The final stage of a root-only build keeps the comparison but not the difference.
    if (KEEP_REM) begin : g_rem
        logic [c_PREM_W-1:0] w_rem_nx;

        assign w_rem_nx = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rem <= '0;
            end else if (i_vld) begin
                r_rem <= w_rem_nx;
            end
        end
    end else begin : g_no_rem
        assign r_rem = '0;
    end

    assign o_vld  = r_vld;
    assign o_rad  = r_rad;
    assign o_rem  = r_rem;
    assign o_root = r_root;

endmodule
`default_nettype wire

// File: rtl/isqrt_pipe_with_valid.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_pipe_with_valid
// Description : Fully pipelined floor(sqrt(x)), WIDTH/2 stages, valid travels
//               with the data. Define ISQRT_REMAINDER_EN to add out_rem.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_pipe_with_valid
    import isqrt_pkg::*;
#(
    parameter int  WIDTH    = c_DEFAULT_WIDTH,
    localparam int c_STAGES = isqrt_stages(WIDTH),
    localparam int c_ROOT_W = isqrt_root_w(WIDTH),
    localparam int c_PREM_W = isqrt_prem_w(WIDTH),
    localparam int c_REM_W  = isqrt_rem_w(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_vld,
    output logic [c_ROOT_W-1:0] out_root
`ifdef ISQRT_REMAINDER_EN
    ,
    output logic [c_REM_W-1:0]  out_rem
`endif
);

`ifdef ISQRT_REMAINDER_EN
    localparam bit c_LAST_KEEP_REM = 1'b1;
`else
    localparam bit c_LAST_KEEP_REM = 1'b0;
`endif

    if (!isqrt_width_ok(WIDTH)) begin : g_width_check
        $error("isqrt_pipe_with_valid: WIDTH must be even and >= 4");
    end

    logic                w_vld  [0:c_STAGES];
    logic [WIDTH-1:0]    w_rad  [0:c_STAGES];
    logic [c_PREM_W-1:0] w_rem  [0:c_STAGES];
    logic [c_ROOT_W-1:0] w_root [0:c_STAGES];

    assign w_vld[0]  = in_vld;
    assign w_rad[0]  = in_data;
    assign w_rem[0]  = '0;
    assign w_root[0] = '0;

    for (genvar i = 0; i < c_STAGES; i++) begin : g_stage
        isqrt_stage #(
            .WIDTH    (WIDTH),
            .KEEP_REM ((i < c_STAGES - 1) ? 1'b1 : c_LAST_KEEP_REM)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (w_vld[i]),
            .i_rad  (w_rad[i]),
            .i_rem  (w_rem[i]),
            .i_root (w_root[i]),
            .o_vld  (w_vld[i+1]),
            .o_rad  (w_rad[i+1]),
            .o_rem  (w_rem[i+1]),
            .o_root (w_root[i+1])
        );
    end

    assign out_vld  = w_vld[c_STAGES];
    assign out_root = w_root[c_STAGES];
`ifdef ISQRT_REMAINDER_EN
    // Final remainder is at most 2*root, so the top spare bit is always zero.
    assign out_rem  = w_rem[c_STAGES][c_REM_W-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe_with_valid.sv
`default_nettype none
// ============================================================================
// Module      : tb_isqrt_pipe_with_valid
// Description : Directed and random checks of isqrt_pipe_with_valid against a
//               square-root reference model with an 8-deep latency queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_pipe_with_valid;

    localparam int c_W   = 16;
    localparam int c_LAT = c_W / 2;

    typedef struct packed {
        logic            v;
        logic [c_W-1:0]  d;
    } op_t;

    logic             clk;
    logic             rst;
    logic             in_vld;
    logic [c_W-1:0]   in_data;
    logic             out_vld;
    logic [c_W/2-1:0] out_root;
`ifdef ISQRT_REMAINDER_EN
    logic [c_W/2:0]   out_rem;
`endif

    int  checks   = 0;
    int  failures = 0;
    op_t q[$];
    int  last_root = 0;
    int  last_rem  = 0;
    int  vld_seen  = 0;

    isqrt_pipe_with_valid #(.WIDTH(c_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_root (out_root)
`ifdef ISQRT_REMAINDER_EN
        ,
        .out_rem  (out_rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_isqrt(int x);
        int r = int'($floor($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        op_t e;
        e.v = 1'b0;
        e.d = '0;
        q.delete();
        repeat (c_LAT) q.push_back(e);
        last_root = 0;
        last_rem  = 0;
    endtask

    task automatic compare_outputs();
        op_t e;
        e = q.pop_front();
        if (e.v) begin
            last_root = ref_isqrt(int'(e.d));
            last_rem  = int'(e.d) - last_root * last_root;
        end
        if (out_vld === 1'b1) vld_seen++;
        check("out_vld", 32'(out_vld), 32'(e.v));
        check("out_root", 32'(out_root), 32'(last_root));
`ifdef ISQRT_REMAINDER_EN
        check("out_rem", 32'(out_rem), 32'(last_rem));
`endif
    endtask

    // One cycle: compare at the falling edge, then drive the next input.
    task automatic tick(input logic v, input logic [c_W-1:0] d);
        op_t e;
        @(negedge clk);
        compare_outputs();
        in_vld  = v;
        in_data = d;
        e.v = v;
        e.d = d;
        q.push_back(e);
    endtask

    initial begin
        int saved_root;
        int accepted;

        rst     = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        model_reset();
        #2;
        check("reset_vld", 32'(out_vld), 32'd0);
        check("reset_root", 32'(out_root), 32'd0);
        repeat (3) tick(1'b0, 16'(($urandom)));
        rst = 1'b1;

        // Single operand: exactly one pulse, root 12
        vld_seen = 0;
        tick(1'b1, 16'd144);
        repeat (12) tick(1'b0, 16'd0);
        check("x144_pulses", 32'(vld_seen), 32'd1);
        check("x144_root", 32'(out_root), 32'd12);
`ifdef ISQRT_REMAINDER_EN
        check("x144_rem", 32'(out_rem), 32'd0);
`endif

        // Back-to-back operands including both extremes
        tick(1'b1, 16'd143);
        tick(1'b1, 16'd0);
        tick(1'b1, 16'd1);
        tick(1'b1, 16'd65535);
        repeat (10) tick(1'b0, 16'd0);
        check("b2b_last_root", 32'(out_root), 32'd255);
`ifdef ISQRT_REMAINDER_EN
        check("b2b_last_rem", 32'(out_rem), 32'd510);
`endif

        // Bubble pattern 1,0,0,1,0,1
        tick(1'b1, 16'd4);
        tick(1'b0, 16'(($urandom)));
        tick(1'b0, 16'(($urandom)));
        tick(1'b1, 16'd9);
        tick(1'b0, 16'(($urandom)));
        tick(1'b1, 16'd16);
        repeat (10) tick(1'b0, 16'(($urandom)));
        check("bubble_last_root", 32'(out_root), 32'd4);

        // Idle with toggling data: nothing valid, root held
        saved_root = last_root;
        vld_seen = 0;
        repeat (50) tick(1'b0, 16'(($urandom)));
        check("idle_pulses", 32'(vld_seen), 32'd0);
        check("idle_root_hold", 32'(out_root), 32'(saved_root));

        // Asynchronous reset with five operands in flight
        tick(1'b1, 16'd40000);
        tick(1'b1, 16'd2500);
        tick(1'b1, 16'd900);
        tick(1'b1, 16'd64);
        tick(1'b1, 16'd7);
        #2;
        rst    = 1'b0;
        in_vld = 1'b0;
        #1;
        check("async_rst_vld", 32'(out_vld), 32'd0);
        check("async_rst_root", 32'(out_root), 32'd0);
`ifdef ISQRT_REMAINDER_EN
        check("async_rst_rem", 32'(out_rem), 32'd0);
`endif
        model_reset();
        repeat (2) tick(1'b0, 16'd0);
        rst = 1'b1;
        vld_seen = 0;
        repeat (12) tick(1'b0, 16'd0);
        check("post_rst_stale", 32'(vld_seen), 32'd0);
        tick(1'b1, 16'd10000);
        repeat (10) tick(1'b0, 16'd0);
        check("post_rst_root", 32'(out_root), 32'd100);

        // Random operands at roughly 70% valid density
        accepted = 0;
        while (accepted < 10000) begin
            if ($urandom_range(99) < 70) begin
                tick(1'b1, 16'(($urandom)));
                accepted++;
            end else begin
                tick(1'b0, 16'(($urandom)));
            end
        end
        repeat (c_LAT + 2) tick(1'b0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
